// File: rtl/pv_hash_block_buf.sv
// Dword-assembled 1024-bit block buffer with shadow copy feeding a SHA-512 core, plus digest capture.
// Optional PV_HASH_BUF_CLR_ON_ISSUE_EN: zero the working buffer at every snapshot edge.
module pv_hash_block_buf #(
  parameter int BLOCK_W = 1024,
  parameter int DATA_W  = 32,
  parameter int DIG_W   = 512,
  localparam int BLOCK_NO = BLOCK_W / DATA_W,
  localparam int DIG_NO   = DIG_W / DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        zeroize,
  input  logic                        block_we,
  input  logic [$clog2(BLOCK_NO)-1:0] block_offset,
  input  logic [DATA_W-1:0]           block_wr_data,
  input  logic                        gen_hash_init,
  input  logic                        gen_hash_next,
  input  logic                        gen_hash_last,
  input  logic                        core_ready,
  input  logic                        core_digest_valid,
  input  logic [DIG_W-1:0]            core_digest,
  output logic                        core_init,
  output logic                        core_next,
  output logic [BLOCK_W-1:0]          core_block,
  input  logic [$clog2(DIG_NO)-1:0]   digest_rd_idx,
  output logic [DATA_W-1:0]           digest_rd_data,
  output logic                        digest_valid,
  output logic                        busy,
  output logic                        protocol_err
);
  localparam int OFF_W = $clog2(BLOCK_NO);

  typedef enum logic [1:0] {IDLE, ACTIVE, WT_DIG, DONE} state_e;

  state_e             state_q, state_d;
  logic               core_init_q, core_init_d;
  logic               core_next_q, core_next_d;
  logic               digest_valid_q, digest_valid_d;
  logic               protocol_err_q, protocol_err_d;
  logic [BLOCK_W-1:0] shadow_q, shadow_d;
  logic [DIG_W-1:0]   digest_q, digest_d;
  logic [BLOCK_W-1:0] working_flat;
  logic [DATA_W-1:0]  working_q [BLOCK_NO];
  logic [DATA_W-1:0]  working_d [BLOCK_NO];
  logic [DATA_W-1:0]  digest_word [DIG_NO];
  logic               snap;
  logic               clr;

  assign clr = rst | zeroize;

  always_comb begin
    state_d        = state_q;
    core_init_d    = 1'b0;
    core_next_d    = 1'b0;
    digest_valid_d = digest_valid_q;
    protocol_err_d = protocol_err_q;
    digest_d       = digest_q;
    snap           = 1'b0;

    if ((gen_hash_init || gen_hash_next) && !core_ready)
      protocol_err_d = 1'b1;

    if (gen_hash_init) begin
      // init always (re)starts a hash; a simultaneous next is folded into it
      if (gen_hash_next || state_q == ACTIVE || state_q == WT_DIG)
        protocol_err_d = 1'b1;
      snap           = 1'b1;
      core_init_d    = 1'b1;
      digest_valid_d = 1'b0;
      state_d        = ACTIVE;
    end else if (gen_hash_next) begin
      if (state_q == ACTIVE) begin
        snap        = 1'b1;
        core_next_d = 1'b1;
      end else begin
        protocol_err_d = 1'b1;
      end
    end else if (state_q == ACTIVE && gen_hash_last && !core_init_q && !core_next_q) begin
      state_d = WT_DIG;
    end

    if (!gen_hash_init && state_q == WT_DIG && core_digest_valid) begin
      digest_d       = core_digest;
      digest_valid_d = 1'b1;
      state_d        = DONE;
    end

    shadow_d = snap ? working_flat : shadow_q;
  end

  for (genvar gi = 0; gi < BLOCK_NO; gi++) begin : g_work
    always_comb begin
      working_d[gi] = working_q[gi];
`ifdef PV_HASH_BUF_CLR_ON_ISSUE_EN
      if (snap)
        working_d[gi] = '0;
`endif
      // a write in the snapshot cycle lands after the clear
      if (block_we && block_offset == OFF_W'(gi))
        working_d[gi] = block_wr_data;
    end

    always_ff @(posedge clk) begin
      if (clr) working_q[gi] <= '0;
      else     working_q[gi] <= working_d[gi];
    end

    assign working_flat[BLOCK_W-1-gi*DATA_W -: DATA_W] = working_q[gi];
  end

  for (genvar gi = 0; gi < DIG_NO; gi++) begin : g_dig
    assign digest_word[gi] = digest_q[DIG_W-1-gi*DATA_W -: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= IDLE;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      protocol_err_q <= 1'b0;
      shadow_q       <= '0;
      digest_q       <= '0;
    end else begin
      state_q        <= state_d;
      core_init_q    <= core_init_d;
      core_next_q    <= core_next_d;
      digest_valid_q <= digest_valid_d;
      protocol_err_q <= protocol_err_d;
      shadow_q       <= shadow_d;
      digest_q       <= digest_d;
    end
  end

  assign core_init      = core_init_q;
  assign core_next      = core_next_q;
  assign core_block     = shadow_q;
  assign digest_rd_data = digest_word[digest_rd_idx];
  assign digest_valid   = digest_valid_q;
  assign busy           = (state_q != IDLE);
  assign protocol_err   = protocol_err_q;
endmodule

// File: tb/tb_pv_hash_block_buf.sv
// Directed self-checking bench for pv_hash_block_buf; expectations follow PV_HASH_BUF_CLR_ON_ISSUE_EN if defined.
module tb_pv_hash_block_buf;
  logic          clk = 1'b0;
  logic          rst, zeroize, block_we;
  logic [4:0]    block_offset;
  logic [31:0]   block_wr_data;
  logic          gen_hash_init, gen_hash_next, gen_hash_last;
  logic          core_ready, core_digest_valid;
  logic [511:0]  core_digest;
  logic          core_init, core_next;
  logic [1023:0] core_block;
  logic [3:0]    digest_rd_idx;
  logic [31:0]   digest_rd_data;
  logic          digest_valid, busy, protocol_err;

  int checks = 0;
  int errors = 0;

  pv_hash_block_buf dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .block_we(block_we),
    .block_offset(block_offset), .block_wr_data(block_wr_data),
    .gen_hash_init(gen_hash_init), .gen_hash_next(gen_hash_next),
    .gen_hash_last(gen_hash_last), .core_ready(core_ready),
    .core_digest_valid(core_digest_valid), .core_digest(core_digest),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .digest_rd_idx(digest_rd_idx), .digest_rd_data(digest_rd_data),
    .digest_valid(digest_valid), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [31:0] blk_word(input int i);
    return core_block[1023-32*i -: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    block_we = 1'b1; block_offset = 5'(idx); block_wr_data = data;
    tick();
    block_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; zeroize = 1'b0; block_we = 1'b0; block_offset = '0; block_wr_data = '0;
    gen_hash_init = 1'b0; gen_hash_next = 1'b0; gen_hash_last = 1'b0;
    core_ready = 1'b1; core_digest_valid = 1'b0; core_digest = '0; digest_rd_idx = '0;
    do_reset();

    chk("rst_busy", 32'(busy), 0);
    chk("rst_init", 32'(core_init), 0);
    chk("rst_dvalid", 32'(digest_valid), 0);
    chk("rst_perr", 32'(protocol_err), 0);
    chk("rst_blk0", blk_word(0), 0);
    chk("rst_dig", digest_rd_data, 0);

    // 1: fill block, init
    for (int i = 0; i < 32; i++) wr(i, 32'h1000 + 32'(i));
    gen_hash_init = 1'b1; tick(); gen_hash_init = 1'b0;
    chk("t1_init_pulse", 32'(core_init), 1);
    chk("t1_blk_w0", blk_word(0), 32'h1000);
    chk("t1_blk_w31", core_block[31:0], 32'h101F);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_init_drop", 32'(core_init), 0);

    // 2: refill word 0 while shadow holds the old block
    wr(0, 32'hDEAD);
    chk("t2_blk_hold", blk_word(0), 32'h1000);
    gen_hash_next = 1'b1; tick(); gen_hash_next = 1'b0;
    chk("t2_next_pulse", 32'(core_next), 1);
    chk("t2_blk_w0", blk_word(0), 32'hDEAD);
`ifdef PV_HASH_BUF_CLR_ON_ISSUE_EN
    chk("t2_blk_w31", blk_word(31), 32'h0);
`else
    chk("t2_blk_w31", blk_word(31), 32'h101F);
`endif
    tick();
    chk("t2_next_drop", 32'(core_next), 0);

    // 3: second next, then last, then final digest
    gen_hash_next = 1'b1; tick(); gen_hash_next = 1'b0;
    gen_hash_last = 1'b1; tick(); tick();
    chk("t3_wait_dv", 32'(digest_valid), 0);
    core_digest = '0;
    core_digest[511:480] = 32'hA5A5A5A5;
    core_digest[31:0]    = 32'h000000F0;
    core_digest_valid = 1'b1; tick(); core_digest_valid = 1'b0; gen_hash_last = 1'b0;
    chk("t3_dvalid", 32'(digest_valid), 1);
    digest_rd_idx = 4'd0; #1;
    chk("t3_dig0", digest_rd_data, 32'hA5A5A5A5);
    digest_rd_idx = 4'd15; #1;
    chk("t3_dig15", digest_rd_data, 32'h000000F0);
    chk("t3_perr", 32'(protocol_err), 0);

    // 4: restart from DONE, intermediate digest ignored, strobe with core not ready
    gen_hash_init = 1'b1; tick(); gen_hash_init = 1'b0;
    chk("t4_dv_clr", 32'(digest_valid), 0);
    chk("t4_perr0", 32'(protocol_err), 0);
    core_digest = {16{32'h11111111}};
    core_digest_valid = 1'b1; tick(); core_digest_valid = 1'b0;
    digest_rd_idx = 4'd0; #1;
    chk("t4_dv_ign", 32'(digest_valid), 0);
    chk("t4_dig_keep", digest_rd_data, 32'hA5A5A5A5);
    core_ready = 1'b0; gen_hash_next = 1'b1; tick(); gen_hash_next = 1'b0; core_ready = 1'b1;
    chk("t4_perr", 32'(protocol_err), 1);
    chk("t4_pulse_anyway", 32'(core_next), 1);
    tick(); tick();
    chk("t4_perr_sticky", 32'(protocol_err), 1);

    // 5: zeroize mid-ACTIVE
    zeroize = 1'b1; tick(); zeroize = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_blk0", blk_word(0), 0);
    chk("t5_blk31", blk_word(31), 0);
    chk("t5_dvalid", 32'(digest_valid), 0);
    chk("t5_perr", 32'(protocol_err), 0);
    chk("t5_dig", digest_rd_data, 0);

    // next in IDLE is ignored but flagged
    gen_hash_next = 1'b1; tick(); gen_hash_next = 1'b0;
    chk("idle_next_pulse", 32'(core_next), 0);
    chk("idle_next_perr", 32'(protocol_err), 1);
    chk("idle_next_busy", 32'(busy), 0);

    // init+next together: behaves as init, flags error
    do_reset();
    gen_hash_init = 1'b1; gen_hash_next = 1'b1; tick();
    gen_hash_init = 1'b0; gen_hash_next = 1'b0;
    chk("both_init", 32'(core_init), 1);
    chk("both_next", 32'(core_next), 0);
    chk("both_perr", 32'(protocol_err), 1);

    // 6: same-cycle write excluded from shadow; retention vs clear-on-issue
    do_reset();
    wr(5, 32'h55);
    block_we = 1'b1; block_offset = 5'd7; block_wr_data = 32'h77;
    gen_hash_init = 1'b1; tick();
    gen_hash_init = 1'b0; block_we = 1'b0;
    chk("t6_w5_snap", blk_word(5), 32'h55);
    chk("t6_w7_excl", blk_word(7), 32'h0);
    tick();
    gen_hash_next = 1'b1; tick(); gen_hash_next = 1'b0;
    chk("t6_w7_kept", blk_word(7), 32'h77);
`ifdef PV_HASH_BUF_CLR_ON_ISSUE_EN
    chk("t6_w5_clr", blk_word(5), 32'h0);
`else
    chk("t6_w5_ret", blk_word(5), 32'h55);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
